// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state encodings and default width for the muldiv unit
package muldiv_pkg;

  localparam int MD_WIDTH = 16;

  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_MULH = 2'b01,
    MD_DIV  = 2'b10,
    MD_REM  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } md_state_e;

  function automatic logic is_div_op(input md_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/exe_muldiv_if.sv
// rtl/exe_muldiv_if.sv - execute-stage muldiv handshake bundle (pipeline side = master)
interface exe_muldiv_if #(parameter int WIDTH = 16) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       reg_waddr;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       reg_waddr_out;
  logic             div_by_zero;

  modport slave (
    input  start, op, a, b, reg_waddr, flush,
    output stall, busy, done, result, reg_waddr_out, div_by_zero
  );

  modport master (
    output start, op, a, b, reg_waddr, flush,
    input  stall, busy, done, result, reg_waddr_out, div_by_zero
  );

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add or restoring-divide iteration; divider built only with MULDIV_DIV_EN
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic [2*WIDTH-1:0] prod_in,
`ifdef MULDIV_DIV_EN
  input  logic               is_div,
  input  logic [WIDTH-1:0]   rem_in,
  output logic [WIDTH-1:0]   rem_out,
`endif
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic [2*WIDTH-1:0] prod_out
);

  localparam int PW = 2 * WIDTH;

  logic [WIDTH:0] sum;
  logic [PW:0]    ext;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] r_sh;
`endif

  always_comb begin
    // multiply: a is the multiplicand, b shifts right exposing the next multiplier bit
    sum      = {1'b0, prod_in[PW-1:WIDTH]} + {1'b0, (b_in[0] ? a_in : '0)};
    ext      = {sum, prod_in[WIDTH-1:0]};
    prod_out = PW'(ext >> 1);
    a_out    = a_in;
    b_out    = b_in >> 1;
`ifdef MULDIV_DIV_EN
    // divide: a doubles as the quotient shift register, b stays the divisor
    r_sh    = {rem_in, a_in[WIDTH-1]};
    rem_out = rem_in;
    if (is_div) begin
      prod_out = prod_in;
      b_out    = b_in;
      if (r_sh >= {1'b0, b_in}) begin
        rem_out = WIDTH'(r_sh - {1'b0, b_in});
        a_out   = {a_in[WIDTH-2:0], 1'b1};
      end else begin
        rem_out = r_sh[WIDTH-1:0];
        a_out   = {a_in[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/exe_muldiv.sv
// rtl/exe_muldiv.sv - iterative unsigned mul/div execute unit; MULDIV_DIV_EN enables DIV/REM
module exe_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input logic         clk,
  input logic         rst,
  exe_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  md_op_e             op_q, op_d;
  logic [3:0]         waddr_q, waddr_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         waddr_out_q, waddr_out_d;
  logic               dbz_q, dbz_d, done_q, done_d, busy_q, busy_d;
  logic [WIDTH-1:0]   a_nx, b_nx;
  logic [2*WIDTH-1:0] prod_nx;
`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0]   rem_q, rem_d, rem_nx;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .a_in    (a_q),
    .b_in    (b_q),
    .prod_in (prod_q),
`ifdef MULDIV_DIV_EN
    .is_div  (is_div_op(op_q)),
    .rem_in  (rem_q),
    .rem_out (rem_nx),
`endif
    .a_out   (a_nx),
    .b_out   (b_nx),
    .prod_out(prod_nx)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    op_d        = op_q;
    waddr_d     = waddr_q;
    a_d         = a_q;
    b_d         = b_q;
    prod_d      = prod_q;
    result_d    = result_q;
    waddr_out_d = waddr_out_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
`ifdef MULDIV_DIV_EN
    rem_d       = rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = md_op_e'(bus.op);
          waddr_d = bus.reg_waddr;
          a_d     = bus.a;
          b_d     = bus.b;
          count_d = '0;
          prod_d  = '0;
          state_d = S_RUN;
`ifdef MULDIV_DIV_EN
          rem_d   = '0;
`else
          // no divider: DIV/REM complete immediately with a zero result
          if (is_div_op(md_op_e'(bus.op))) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            result_d    = '0;
            dbz_d       = 1'b0;
            waddr_out_d = bus.reg_waddr;
          end
`endif
        end
      end
      S_RUN: begin
        a_d     = a_nx;
        b_d     = b_nx;
        prod_d  = prod_nx;
        count_d = count_q + 1'b1;
`ifdef MULDIV_DIV_EN
        rem_d   = rem_nx;
`endif
        if (count_q == CW'(WIDTH - 1)) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          waddr_out_d = waddr_q;
          case (op_q)
            MD_MULH: result_d = prod_nx[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
            MD_DIV:  result_d = a_nx;
            MD_REM:  result_d = rem_nx;
`endif
            default: result_d = prod_nx[WIDTH-1:0];
          endcase
`ifdef MULDIV_DIV_EN
          dbz_d = is_div_op(op_q) && (b_q == '0);
`else
          dbz_d = 1'b0;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // flush kills the operation and leaves the last delivered result untouched
    if (bus.flush) begin
      state_d     = S_IDLE;
      done_d      = 1'b0;
      result_d    = result_q;
      waddr_out_d = waddr_out_q;
      dbz_d       = dbz_q;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      op_q        <= MD_MUL;
      waddr_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      result_q    <= '0;
      waddr_out_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      op_q        <= op_d;
      waddr_q     <= waddr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prod_q      <= prod_d;
      result_q    <= result_d;
      waddr_out_q <= waddr_out_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
`ifdef MULDIV_DIV_EN
      rem_q       <= rem_d;
`endif
    end
  end

  assign bus.stall = ~rst & (((state_q == S_IDLE) & bus.start & ~bus.flush) | (state_q == S_RUN));
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.result        = result_q;
  assign bus.reg_waddr_out = waddr_out_q;
  assign bus.div_by_zero   = dbz_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// tb/tb_exe_muldiv.sv - scoreboard bench for exe_muldiv; expectations follow MULDIV_DIV_EN
module tb_exe_muldiv;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  wa;
    logic        dbz;
    int          lat;
    int          stl;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  exe_muldiv_if #(.WIDTH(16)) mif ();

  exe_muldiv #(.WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(mif)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] wa);
    exp_t        e;
    logic [31:0] p;
    p     = {16'd0, a} * {16'd0, b};
    e.wa  = wa;
    e.lat = 18;
    e.stl = 17;
    e.dbz = op[1] && (b == 16'd0);
    case (op)
      2'b00:   e.res = p[15:0];
      2'b01:   e.res = p[31:16];
      2'b10:   e.res = (b == 16'd0) ? 16'hFFFF : a / b;
      default: e.res = (b == 16'd0) ? a : a % b;
    endcase
`ifndef MULDIV_DIV_EN
    if (op[1]) begin
      e.res = 16'd0;
      e.dbz = 1'b0;
      e.lat = 2;
      e.stl = 1;
    end
`endif
    return e;
  endfunction

  // drives one instruction from a negedge, returns at the negedge of the IDLE cycle after done
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] wa, input bit scramble,
                        output logic [15:0] res, output logic [3:0] wa_o, output logic dbz,
                        output int lat, output int stl);
    lat = 0; stl = 0; res = '0; wa_o = '0; dbz = 1'b0;
    mif.start = 1'b1; mif.op = op; mif.a = a; mif.b = b; mif.reg_waddr = wa;
    for (int i = 1; i <= 40; i++) begin
      #1;
      if (mif.stall) stl++;
      if (mif.done) begin
        lat = i; res = mif.result; wa_o = mif.reg_waddr_out; dbz = mif.div_by_zero;
      end
      if (scramble && i == 4) begin
        mif.a = ~a; mif.b = a ^ b; mif.op = ~op;
      end
      @(negedge clk);
      if (lat != 0) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; mif.flush = 1'b0;
    mif.start = 1'b1; mif.op = 2'b00; mif.a = 16'd9; mif.b = 16'd9; mif.reg_waddr = 4'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++; if (mif.stall !== 1'b0) begin errors++; $display("FAIL reset_stall[%0d] got %b exp 0", i, mif.stall); end
    end
    checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", mif.busy); end
    checks++; if (mif.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", mif.done); end
    checks++; if (mif.result !== 16'h0) begin errors++; $display("FAIL reset_result got %h exp 0000", mif.result); end
    checks++; if (mif.reg_waddr_out !== 4'h0) begin errors++; $display("FAIL reset_waddr got %h exp 0", mif.reg_waddr_out); end
    checks++; if (mif.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b exp 0", mif.div_by_zero); end
    rst = 1'b0; mif.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul;
    logic [1:0]  ops[5] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
    logic [15:0] as[5]  = '{16'd300, 16'd300, 16'hFFFF, 16'hFFFF, 16'h0000};
    logic [15:0] bs[5]  = '{16'd300, 16'd300, 16'hFFFF, 16'hFFFF, 16'h1234};
    logic [3:0]  ws[5]  = '{4'd5, 4'd5, 4'd15, 4'd14, 4'd1};
    exp_t e; logic [15:0] r; logic [3:0] w; logic z; int lat, stl;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(model(ops[i], as[i], bs[i], ws[i]));
      run_op(ops[i], as[i], bs[i], ws[i], 1'b0, r, w, z, lat, stl);
      mif.start = 1'b0;
      e = sb.pop_front();
      checks++; if (r !== e.res) begin errors++; $display("FAIL mul[%0d]_result got %h exp %h", i, r, e.res); end
      checks++; if (w !== e.wa) begin errors++; $display("FAIL mul[%0d]_waddr got %h exp %h", i, w, e.wa); end
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL mul[%0d]_done_cycle got %0d exp %0d", i, lat, e.lat); end
      checks++; if (stl !== e.stl) begin errors++; $display("FAIL mul[%0d]_stall_cycles got %0d exp %0d", i, stl, e.stl); end
      @(negedge clk);
    end
  endtask

  task automatic test_div;
    logic [1:0]  ops[6] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11};
    logic [15:0] as[6]  = '{16'd1000, 16'd1000, 16'd1234, 16'd1234, 16'hFFFF, 16'hBEEF};
    logic [15:0] bs[6]  = '{16'd7, 16'd7, 16'd0, 16'd0, 16'd1, 16'h00FF};
    exp_t e; logic [15:0] r; logic [3:0] w; logic z; int lat, stl;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(model(ops[i], as[i], bs[i], 4'(i + 8)));
      run_op(ops[i], as[i], bs[i], 4'(i + 8), 1'b0, r, w, z, lat, stl);
      mif.start = 1'b0;
      e = sb.pop_front();
      checks++; if (r !== e.res) begin errors++; $display("FAIL div[%0d]_result got %h exp %h", i, r, e.res); end
      checks++; if (z !== e.dbz) begin errors++; $display("FAIL div[%0d]_dbz got %b exp %b", i, z, e.dbz); end
      checks++; if (w !== e.wa) begin errors++; $display("FAIL div[%0d]_waddr got %h exp %h", i, w, e.wa); end
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL div[%0d]_done_cycle got %0d exp %0d", i, lat, e.lat); end
      checks++; if (stl !== e.stl) begin errors++; $display("FAIL div[%0d]_stall_cycles got %0d exp %0d", i, stl, e.stl); end
      @(negedge clk);
    end
  endtask

  task automatic test_flush;
    exp_t e; logic [15:0] r; logic [3:0] w; logic z; int lat, stl; int ndone;
    sb.push_back(model(2'b00, 16'd2, 16'd3, 4'd1));
    run_op(2'b00, 16'd2, 16'd3, 4'd1, 1'b0, r, w, z, lat, stl);
    e = sb.pop_front();
    checks++; if (r !== e.res) begin errors++; $display("FAIL flush_prior_result got %h exp %h", r, e.res); end
    mif.start = 1'b1; mif.op = 2'b00; mif.a = 16'd3; mif.b = 16'd4; mif.reg_waddr = 4'd2;
    repeat (8) @(negedge clk);
    mif.flush = 1'b1; mif.start = 1'b0; #1;
    checks++; if (mif.busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before got %b exp 1", mif.busy); end
    @(negedge clk); mif.flush = 1'b0; #1;
    checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after got %b exp 0", mif.busy); end
    checks++; if (mif.stall !== 1'b0) begin errors++; $display("FAIL flush_stall_after got %b exp 0", mif.stall); end
    ndone = 0;
    repeat (25) begin
      if (mif.done) ndone++;
      @(negedge clk); #1;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL flush_no_done got %0d exp 0", ndone); end
    checks++; if (mif.result !== 16'h0006) begin errors++; $display("FAIL flush_result_kept got %h exp 0006", mif.result); end
    checks++; if (mif.reg_waddr_out !== 4'd1) begin errors++; $display("FAIL flush_waddr_kept got %h exp 1", mif.reg_waddr_out); end
    sb.push_back(model(2'b00, 16'd3, 16'd4, 4'd2));
    run_op(2'b00, 16'd3, 16'd4, 4'd2, 1'b0, r, w, z, lat, stl);
    mif.start = 1'b0;
    e = sb.pop_front();
    checks++; if (r !== e.res) begin errors++; $display("FAIL flush_recover_result got %h exp %h", r, e.res); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL flush_recover_done_cycle got %0d exp %0d", lat, e.lat); end
    @(negedge clk);
  endtask

  task automatic test_latched_operands;
    exp_t e; logic [15:0] r; logic [3:0] w; logic z; int lat, stl;
    sb.push_back(model(2'b00, 16'h1234, 16'h00AB, 4'd7));
    run_op(2'b00, 16'h1234, 16'h00AB, 4'd7, 1'b1, r, w, z, lat, stl);
    mif.start = 1'b0;
    e = sb.pop_front();
    checks++; if (r !== e.res) begin errors++; $display("FAIL latched_result got %h exp %h", r, e.res); end
    checks++; if (w !== e.wa) begin errors++; $display("FAIL latched_waddr got %h exp %h", w, e.wa); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp_t e; logic [15:0] r; logic [3:0] w; logic z; int lat, stl; int ndone;
    logic [15:0] ra = 16'($urandom_range(1, 16'hFFFF));
    logic [15:0] rb = 16'($urandom_range(1, 16'hFF));
    sb.push_back(model(2'b00, ra, rb, 4'd4));
    sb.push_back(model(2'b10, 16'd1000, 16'd7, 4'd9));
    run_op(2'b00, ra, rb, 4'd4, 1'b0, r, w, z, lat, stl);
    e = sb.pop_front();
    checks++; if (r !== e.res) begin errors++; $display("FAIL b2b_first_result got %h exp %h", r, e.res); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL b2b_first_done_cycle got %0d exp %0d", lat, e.lat); end
    run_op(2'b10, 16'd1000, 16'd7, 4'd9, 1'b0, r, w, z, lat, stl);
    e = sb.pop_front();
    checks++; if (r !== e.res) begin errors++; $display("FAIL b2b_second_result got %h exp %h", r, e.res); end
    checks++; if (w !== e.wa) begin errors++; $display("FAIL b2b_second_waddr got %h exp %h", w, e.wa); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL b2b_second_done_cycle got %0d exp %0d", lat, e.lat); end
    mif.start = 1'b0;
    ndone = 0;
    repeat (25) begin
      #1; if (mif.done) ndone++;
      @(negedge clk);
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL b2b_extra_done got %0d exp 0", ndone); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    mif.start = 1'b0; mif.op = 2'b00; mif.a = '0; mif.b = '0;
    mif.reg_waddr = '0; mif.flush = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_flush();
    test_latched_operands();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
